mips_data_bridge: RTL

- Sits between the data port of the Harvard MIPS CPU and a slower shared data memory that uses a valid/wait handshake.
- Converts the CPU's combinational-read / single-cycle-write data port into multi-cycle bus transactions.
- Stalls the CPU by dropping its clock enable until each access completes.
- Also polices access alignment and bus timeouts, and records faults in a sticky error flag.

---
 rtl/mips_data_bridge.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/mips_data_bridge.sv
// -----------------------------------------------------------------------------
// mips_data_bridge
//
// Bridges the data port of a Harvard MIPS CPU (combinational read, single-cycle
// write) onto a slower shared data memory that uses a valid/wait handshake.
// Every CPU access becomes a multi-cycle bus transaction, and the CPU is frozen
// through its clock enable until that transaction has completed. Misaligned
// accesses and bus timeouts are turned into a harmless completion and recorded
// in a sticky error flag.
//
// Ports:
//   clk                 system clock, all state updates on the rising edge
//   reset               synchronous, active-high reset
//   cpu_data_address    CPU byte address
//   cpu_data_write      CPU write request
//   cpu_data_read       CPU read request
//   cpu_data_writedata  CPU write data
//   cpu_data_readdata   read data to the CPU (holds the last completed read)
//   cpu_clk_enable      clock enable to the CPU, 0 freezes it
//   mem_address         word-aligned byte address to memory
//   mem_read            bus read request
//   mem_write           bus write request
//   mem_writedata       bus write data
//   mem_waitrequest     memory is not accepting the current request
//   mem_readdata        bus read data
//   mem_readdatavalid   mem_readdata is valid this cycle
//   error               sticky fault flag, cleared only by reset
//
// Parameters:
//   TIMEOUT   cycles to wait for bus progress before aborting (2..255)
//   ERR_DATA  read data returned on a misaligned or timed-out read
// -----------------------------------------------------------------------------
module mips_data_bridge #(
    parameter int unsigned TIMEOUT  = 64,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_data_address,
    input  logic        cpu_data_write,
    input  logic        cpu_data_read,
    input  logic [31:0] cpu_data_writedata,
    output logic [31:0] cpu_data_readdata,
    output logic        cpu_clk_enable,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    input  logic        mem_waitrequest,
    input  logic [31:0] mem_readdata,
    input  logic        mem_readdatavalid,
    output logic        error
);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        DONE
    } state_t;

    // Last count value before a stalled bus phase is abandoned.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q,   cnt_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        error_q, error_d;

    logic        cpu_req;
    logic        misaligned;
    logic        cnt_expired;

    assign cpu_req     = cpu_data_read | cpu_data_write;
    assign misaligned  = (cpu_data_address[1:0] != 2'b00);
    assign cnt_expired = (cnt_q == CNT_LAST);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case
        // leaves one unassigned, which would otherwise infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        error_d = error_q;

        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    cnt_d = '0;
                    if (misaligned) begin
                        // No bus cycle at all; a read completes with the error
                        // pattern, a write is simply dropped.
                        error_d = 1'b1;
                        state_d = DONE;
                        if (cpu_data_read) begin
                            rdata_d = ERR_DATA;
                        end
                    end else if (cpu_data_read) begin
                        // Read wins a simultaneous read/write, which is flagged.
                        addr_d  = cpu_data_address;
                        state_d = RD_REQ;
                        if (cpu_data_write) begin
                            error_d = 1'b1;
                        end
                    end else begin
                        addr_d  = cpu_data_address;
                        wdata_d = cpu_data_writedata;
                        state_d = WR_REQ;
                    end
                end
            end

            RD_REQ: begin
                if (!mem_waitrequest) begin
                    state_d = RD_WAIT;
                    cnt_d   = '0;
                end else if (cnt_expired) begin
                    error_d = 1'b1;
                    rdata_d = ERR_DATA;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            RD_WAIT: begin
                // Data arriving on the last allowed cycle still counts.
                if (mem_readdatavalid) begin
                    rdata_d = mem_readdata;
                    state_d = DONE;
                end else if (cnt_expired) begin
                    error_d = 1'b1;
                    rdata_d = ERR_DATA;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            WR_REQ: begin
                if (!mem_waitrequest) begin
                    state_d = DONE;
                end else if (cnt_expired) begin
                    error_d = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (reset) begin
            // NOTE: the address and write-data latches are reset too, because
            // they drive mem_address and mem_writedata directly and those must
            // read zero after reset.
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs, decoded from registered state only (apart from the clock enable)
    // -------------------------------------------------------------------------
    assign mem_read          = (state_q == RD_REQ);
    assign mem_write         = (state_q == WR_REQ);
    assign mem_address       = addr_q;
    assign mem_writedata     = wdata_q;
    assign cpu_data_readdata = rdata_q;
    assign error             = error_q;

    // The CPU runs when it has nothing to ask for, and for the single DONE
    // cycle that lets it consume the result and present its next request.
    assign cpu_clk_enable = (state_q == DONE) || ((state_q == IDLE) && !cpu_req);

endmodule
